// File: rtl/vram_burst_control.sv
// vram_burst_control: byte-stream command decoder driving a multi-lane VRAM bus.
// Accepts opcode+arg byte pairs from the host bridge. Runs burst read/write bus
// cycles with address auto-increment, a per-lane write mask and programmable
// strobe timing. Response bytes go back to the host with valid/ready backpressure.
//
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   read_data_i/valid_i  host command/data byte stream (no backpressure)
//   write_data_o/valid_o response byte to host, held until write_ready_i
//   write_ready_i        host accepts the response byte
//   busy_o               controller not idle
//   va_o                 VRAM address, 0 outside bus cycles
//   vrd_n_o              read strobe, active low
//   vwr_n_o              per-lane write strobe, active low
//   lvl_vd_dir_o         1 = FPGA drives the data lanes
//   vd_o / vd_i          lane data out / in, lane k = [8k+7:8k]
//   error_bad_opcode_o   sticky unknown-opcode flag
//   error_bad_timing_o   sticky inconsistent-timing flag
module vram_burst_control #(
  parameter int unsigned ADDR_BITS   = 15,
  parameter int unsigned LANES       = 2,
  parameter int unsigned TIMING_BITS = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             read_data_i,
  input  logic                   read_valid_i,
  output logic [7:0]             write_data_o,
  output logic                   write_valid_o,
  input  logic                   write_ready_i,
  output logic                   busy_o,
  output logic [ADDR_BITS-1:0]   va_o,
  output logic                   vrd_n_o,
  output logic [LANES-1:0]       vwr_n_o,
  output logic                   lvl_vd_dir_o,
  output logic [8*LANES-1:0]     vd_o,
  input  logic [8*LANES-1:0]     vd_i,
  output logic                   error_bad_opcode_o,
  output logic                   error_bad_timing_o
);

  localparam int unsigned DW    = 8 * LANES;
  localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned REM_W = 9;
  localparam int unsigned TW    = TIMING_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_ARG, S_EXECUTE, S_WAIT_DATA, S_CYCLE, S_DRAIN, S_OUTPUT
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           opcode_q, opcode_d;
  logic [7:0]           arg_q, arg_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [TW-1:0]        t_asrt_q, t_asrt_d;
  logic [TW-1:0]        t_smpl_q, t_smpl_d;
  logic [TW-1:0]        t_rels_q, t_rels_d;
  logic [TW-1:0]        t_dur_q, t_dur_d;
  logic [LANES-1:0]     mask_q, mask_d;
  logic [REM_W-1:0]     rem_q, rem_d;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 is_wr_q, is_wr_d;
  logic                 act_q, act_d;
  logic [DW-1:0]        rbuf_q, rbuf_d;
  logic [DW-1:0]        wbuf_q, wbuf_d;
  logic [7:0]           out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic [ADDR_BITS-1:0] va_q, va_d;
  logic                 vrd_n_q, vrd_n_d;
  logic [LANES-1:0]     vwr_n_q, vwr_n_d;
  logic                 dir_q, dir_d;
  logic [DW-1:0]        vd_q, vd_d;
  logic                 err_op_q, err_op_d;
  logic                 err_tim_q, err_tim_d;

  logic [23:0]          addr_ext;
  logic                 timing_ok;
  logic [IDX_W-1:0]     idx_nxt;

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      opcode_q    <= '0;
      arg_q       <= '0;
      addr_q      <= '0;
      t_asrt_q    <= TW'(15);
      t_smpl_q    <= TW'(31);
      t_rels_q    <= TW'(47);
      t_dur_q     <= TW'(63);
      mask_q      <= '1;
      rem_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      is_wr_q     <= 1'b0;
      act_q       <= 1'b0;
      rbuf_q      <= '0;
      wbuf_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      va_q        <= '0;
      vrd_n_q     <= 1'b1;
      vwr_n_q     <= '1;
      dir_q       <= 1'b0;
      vd_q        <= '0;
      err_op_q    <= 1'b0;
      err_tim_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      arg_q       <= arg_d;
      addr_q      <= addr_d;
      t_asrt_q    <= t_asrt_d;
      t_smpl_q    <= t_smpl_d;
      t_rels_q    <= t_rels_d;
      t_dur_q     <= t_dur_d;
      mask_q      <= mask_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      is_wr_q     <= is_wr_d;
      act_q       <= act_d;
      rbuf_q      <= rbuf_d;
      wbuf_q      <= wbuf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      va_q        <= va_d;
      vrd_n_q     <= vrd_n_d;
      vwr_n_q     <= vwr_n_d;
      dir_q       <= dir_d;
      vd_q        <= vd_d;
      err_op_q    <= err_op_d;
      err_tim_q   <= err_tim_d;
    end
  end

  assign timing_ok = (t_asrt_q < t_smpl_q) && (t_smpl_q < t_rels_q) && (t_rels_q <= t_dur_q);
  assign idx_nxt   = idx_q + IDX_W'(1);

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    arg_d       = arg_q;
    addr_d      = addr_q;
    t_asrt_d    = t_asrt_q;
    t_smpl_d    = t_smpl_q;
    t_rels_d    = t_rels_q;
    t_dur_d     = t_dur_q;
    mask_d      = mask_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    is_wr_d     = is_wr_q;
    act_d       = act_q;
    rbuf_d      = rbuf_q;
    wbuf_d      = wbuf_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_op_d    = err_op_q;
    err_tim_d   = err_tim_q;
    addr_ext    = 24'(addr_q);

    unique case (state_q)
      S_IDLE: begin
        if (read_valid_i) begin
          opcode_d = read_data_i;
          state_d  = S_WAIT_ARG;
        end
      end

      S_WAIT_ARG: begin
        if (read_valid_i) begin
          arg_d   = read_data_i;
          state_d = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        state_d = S_IDLE;
        case (opcode_q)
          8'h00: ;
          8'h01: begin
            out_data_d  = arg_q;
            out_valid_d = 1'b1;
            state_d     = S_OUTPUT;
          end
          8'h10: begin
            opcode_d  = '0;
            arg_d     = '0;
            addr_d    = '0;
            t_asrt_d  = TW'(15);
            t_smpl_d  = TW'(31);
            t_rels_d  = TW'(47);
            t_dur_d   = TW'(63);
            mask_d    = '1;
            rem_d     = '0;
            cnt_d     = '0;
            idx_d     = '0;
            is_wr_d   = 1'b0;
            act_d     = 1'b0;
            rbuf_d    = '0;
            wbuf_d    = '0;
            out_data_d = '0;
            err_op_d  = 1'b0;
            err_tim_d = 1'b0;
          end
          // Address bytes above ADDR_BITS fall off in the truncating cast
          8'h20: begin addr_ext[7:0]   = arg_q; addr_d = ADDR_BITS'(addr_ext); end
          8'h21: begin addr_ext[15:8]  = arg_q; addr_d = ADDR_BITS'(addr_ext); end
          8'h22: begin addr_ext[23:16] = arg_q; addr_d = ADDR_BITS'(addr_ext); end
          8'h30: begin out_data_d = addr_ext[7:0];   out_valid_d = 1'b1; state_d = S_OUTPUT; end
          8'h31: begin out_data_d = addr_ext[15:8];  out_valid_d = 1'b1; state_d = S_OUTPUT; end
          8'h32: begin out_data_d = addr_ext[23:16]; out_valid_d = 1'b1; state_d = S_OUTPUT; end
          8'h40: mask_d   = LANES'(arg_q);
          8'h60: t_asrt_d = TW'(arg_q);
          8'h61: t_smpl_d = TW'(arg_q);
          8'h62: t_rels_d = TW'(arg_q);
          8'h63: t_dur_d  = TW'(arg_q);
          8'h70, 8'h71: begin
            if (!timing_ok) begin
              err_tim_d = 1'b1;
            end else begin
              rem_d   = REM_W'(arg_q) + REM_W'(1);
              is_wr_d = opcode_q[0];
              cnt_d   = '0;
              act_d   = 1'b0;
              idx_d   = '0;
              state_d = opcode_q[0] ? S_WAIT_DATA : S_CYCLE;
            end
          end
          default: err_op_d = 1'b1;
        endcase
      end

      // Every lane consumes a byte, masked or not
      S_WAIT_DATA: begin
        if (read_valid_i) begin
          wbuf_d[8*int'(idx_q) +: 8] = read_data_i;
          if (idx_q == IDX_W'(LANES - 1)) begin
            idx_d   = '0;
            cnt_d   = '0;
            act_d   = 1'b0;
            state_d = S_CYCLE;
          end else begin
            idx_d = idx_nxt;
          end
        end
      end

      // act_d takes effect one clock later: strobe low for counts assert+1..release
      S_CYCLE: begin
        if (cnt_q == t_asrt_q) act_d = 1'b1;
        if (cnt_q == t_rels_q) act_d = 1'b0;
        if (!is_wr_q && (cnt_q == t_smpl_q)) rbuf_d = vd_i;
        if (cnt_q == t_dur_q) begin
          addr_d = addr_q + ADDR_BITS'(1);
          rem_d  = rem_q - REM_W'(1);
          cnt_d  = '0;
          act_d  = 1'b0;
          idx_d  = '0;
          if (is_wr_q) begin
            state_d = (rem_d == '0) ? S_IDLE : S_WAIT_DATA;
          end else begin
            out_data_d  = rbuf_d[7:0];
            out_valid_d = 1'b1;
            state_d     = S_DRAIN;
          end
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end

      S_DRAIN: begin
        if (write_ready_i) begin
          if (idx_q == IDX_W'(LANES - 1)) begin
            out_valid_d = 1'b0;
            idx_d       = '0;
            state_d     = (rem_q == '0) ? S_IDLE : S_CYCLE;
          end else begin
            idx_d      = idx_nxt;
            out_data_d = rbuf_q[8*int'(idx_nxt) +: 8];
          end
        end
      end

      S_OUTPUT: begin
        if (write_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Pin registers follow the state being entered
    busy_d  = (state_d != S_IDLE);
    va_d    = (state_d == S_CYCLE) ? addr_d : '0;
    dir_d   = (state_d == S_CYCLE) && is_wr_d;
    vd_d    = dir_d ? wbuf_d : '0;
    vrd_n_d = !((state_d == S_CYCLE) && !is_wr_d && act_d);
    vwr_n_d = ((state_d == S_CYCLE) && is_wr_d && act_d) ? ~mask_d : '1;
  end

  assign write_data_o       = out_data_q;
  assign write_valid_o      = out_valid_q;
  assign busy_o             = busy_q;
  assign va_o               = va_q;
  assign vrd_n_o            = vrd_n_q;
  assign vwr_n_o            = vwr_n_q;
  assign lvl_vd_dir_o       = dir_q;
  assign vd_o               = vd_q;
  assign error_bad_opcode_o = err_op_q;
  assign error_bad_timing_o = err_tim_q;

endmodule

// File: tb/tb_vram_burst_control.sv
// Directed bench for vram_burst_control with default parameters
// (ADDR_BITS=15, LANES=2, TIMING_BITS=6). Inputs change and outputs are
// checked on the falling clock edge.
module tb_vram_burst_control;

  logic        clock;
  logic        reset;
  logic [7:0]  read_data_i;
  logic        read_valid_i;
  logic [7:0]  write_data_o;
  logic        write_valid_o;
  logic        write_ready_i;
  logic        busy_o;
  logic [14:0] va_o;
  logic        vrd_n_o;
  logic [1:0]  vwr_n_o;
  logic        lvl_vd_dir_o;
  logic [15:0] vd_o;
  logic [15:0] vd_i;
  logic        error_bad_opcode_o;
  logic        error_bad_timing_o;

  int n_checks = 0;
  int n_fail   = 0;

  vram_burst_control dut (
    .clock              (clock),
    .reset              (reset),
    .read_data_i        (read_data_i),
    .read_valid_i       (read_valid_i),
    .write_data_o       (write_data_o),
    .write_valid_o      (write_valid_o),
    .write_ready_i      (write_ready_i),
    .busy_o             (busy_o),
    .va_o               (va_o),
    .vrd_n_o            (vrd_n_o),
    .vwr_n_o            (vwr_n_o),
    .lvl_vd_dir_o       (lvl_vd_dir_o),
    .vd_o               (vd_o),
    .vd_i               (vd_i),
    .error_bad_opcode_o (error_bad_opcode_o),
    .error_bad_timing_o (error_bad_timing_o)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One byte, visible to exactly one rising edge
  task automatic send(input logic [7:0] b);
    read_data_i  = b;
    read_valid_i = 1'b1;
    @(negedge clock);
    read_valid_i = 1'b0;
    read_data_i  = 8'h00;
  endtask

  // Opcode + arg, then step past EXECUTE
  task automatic cmd(input logic [7:0] op, input logic [7:0] arg);
    send(op);
    send(arg);
    @(negedge clock);
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (busy_o && k < bound) begin
      @(negedge clock);
      k++;
    end
    check("idle_timeout", 32'(busy_o), 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    read_data_i   = 8'h00;
    read_valid_i  = 1'b0;
    write_ready_i = 1'b0;
    vd_i          = 16'hBBAA;
    repeat (3) @(negedge clock);

    // Reset state
    check("rst_busy",  32'(busy_o), 32'd0);
    check("rst_va",    32'(va_o), 32'd0);
    check("rst_vrd",   32'(vrd_n_o), 32'd1);
    check("rst_vwr",   32'(vwr_n_o), 32'h3);
    check("rst_dir",   32'(lvl_vd_dir_o), 32'd0);
    check("rst_vd",    32'(vd_o), 32'd0);
    check("rst_wval",  32'(write_valid_o), 32'd0);
    check("rst_eop",   32'(error_bad_opcode_o), 32'd0);
    check("rst_etim",  32'(error_bad_timing_o), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // ECHO with host ready: one valid cycle, then idle
    write_ready_i = 1'b1;
    cmd(8'h01, 8'h5A);
    check("echo_valid", 32'(write_valid_o), 32'd1);
    check("echo_data",  32'(write_data_o), 32'h5A);
    check("echo_busy",  32'(busy_o), 32'd1);
    @(negedge clock);
    check("echo_valid_drop", 32'(write_valid_o), 32'd0);
    check("echo_idle",       32'(busy_o), 32'd0);

    // Burst read of 3 cycles at 0x1234, timing 2/4/6/7
    cmd(8'h20, 8'h34);
    cmd(8'h21, 8'h12);
    cmd(8'h60, 8'd2);
    cmd(8'h61, 8'd4);
    cmd(8'h62, 8'd6);
    cmd(8'h63, 8'd7);
    cmd(8'h70, 8'd2);
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 8; c++) begin
        check("rd_va",   32'(va_o), 32'h1234 + 32'(k));
        check("rd_vrd",  32'(vrd_n_o), (c >= 3 && c <= 6) ? 32'd0 : 32'd1);
        check("rd_vwr",  32'(vwr_n_o), 32'h3);
        check("rd_dir",  32'(lvl_vd_dir_o), 32'd0);
        @(negedge clock);
      end
      check("rd_b0_valid", 32'(write_valid_o), 32'd1);
      check("rd_b0_data",  32'(write_data_o), 32'hAA);
      check("rd_drain_va", 32'(va_o), 32'd0);
      @(negedge clock);
      check("rd_b1_valid", 32'(write_valid_o), 32'd1);
      check("rd_b1_data",  32'(write_data_o), 32'hBB);
      @(negedge clock);
    end
    check("rd_done_busy",  32'(busy_o), 32'd0);
    check("rd_done_valid", 32'(write_valid_o), 32'd0);
    cmd(8'h30, 8'h00);
    check("rd_addr_low", 32'(write_data_o), 32'h37);
    @(negedge clock);
    cmd(8'h31, 8'h00);
    check("rd_addr_mid", 32'(write_data_o), 32'h12);
    @(negedge clock);

    // Same read with host stalling the first byte for 20 clocks
    cmd(8'h20, 8'h34);
    write_ready_i = 1'b0;
    cmd(8'h70, 8'd2);
    repeat (8) @(negedge clock);
    check("bp_b0_valid", 32'(write_valid_o), 32'd1);
    check("bp_b0_data",  32'(write_data_o), 32'hAA);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("bp_hold_vrd",   32'(vrd_n_o), 32'd1);
      check("bp_hold_va",    32'(va_o), 32'd0);
      check("bp_hold_valid", 32'(write_valid_o), 32'd1);
      check("bp_hold_data",  32'(write_data_o), 32'hAA);
    end
    write_ready_i = 1'b1;
    @(negedge clock);
    check("bp_b1_data", 32'(write_data_o), 32'hBB);
    @(negedge clock);
    check("bp_cycle2_va", 32'(va_o), 32'h1235);
    wait_idle(100);
    cmd(8'h30, 8'h00);
    check("bp_addr_low", 32'(write_data_o), 32'h37);
    @(negedge clock);

    // Address truncation, lane mask and wrapping burst write
    cmd(8'h20, 8'hFF);
    cmd(8'h21, 8'hFF);
    cmd(8'h22, 8'hFF);
    cmd(8'h31, 8'h00);
    check("wr_addr_mid_trunc", 32'(write_data_o), 32'h7F);
    @(negedge clock);
    cmd(8'h32, 8'h00);
    check("wr_addr_high_zero", 32'(write_data_o), 32'h00);
    @(negedge clock);
    cmd(8'h40, 8'h02);
    cmd(8'h71, 8'd1);
    check("wr_wait_busy", 32'(busy_o), 32'd1);
    check("wr_wait_dir",  32'(lvl_vd_dir_o), 32'd0);
    for (int k = 0; k < 2; k++) begin
      send((k == 0) ? 8'h11 : 8'h33);
      send((k == 0) ? 8'h22 : 8'h44);
      for (int c = 0; c < 8; c++) begin
        check("wr_va",  32'(va_o), (k == 0) ? 32'h7FFF : 32'h0000);
        check("wr_vd",  32'(vd_o), (k == 0) ? 32'h2211 : 32'h4433);
        check("wr_dir", 32'(lvl_vd_dir_o), 32'd1);
        check("wr_vwr", 32'(vwr_n_o), (c >= 3 && c <= 6) ? 32'h1 : 32'h3);
        check("wr_vrd", 32'(vrd_n_o), 32'd1);
        @(negedge clock);
      end
      check("wr_gap_dir", 32'(lvl_vd_dir_o), 32'd0);
      check("wr_gap_vd",  32'(vd_o), 32'd0);
    end
    check("wr_done_busy", 32'(busy_o), 32'd0);
    cmd(8'h30, 8'h00);
    check("wr_addr_low", 32'(write_data_o), 32'h01);
    @(negedge clock);
    cmd(8'h31, 8'h00);
    check("wr_addr_mid", 32'(write_data_o), 32'h00);
    @(negedge clock);

    // Inconsistent timing: burst skipped, flag set, RESET opcode clears it
    cmd(8'h60, 8'd5);
    cmd(8'h61, 8'd5);
    cmd(8'h62, 8'd6);
    cmd(8'h63, 8'd7);
    cmd(8'h70, 8'd0);
    check("tim_err",  32'(error_bad_timing_o), 32'd1);
    check("tim_busy", 32'(busy_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("tim_no_strobe", 32'(vrd_n_o), 32'd1);
      @(negedge clock);
    end
    cmd(8'h10, 8'h00);
    check("tim_err_clr", 32'(error_bad_timing_o), 32'd0);

    // Reset in the middle of a strobed read cycle
    cmd(8'h60, 8'd2);
    cmd(8'h61, 8'd4);
    cmd(8'h62, 8'd6);
    cmd(8'h63, 8'd7);
    cmd(8'h70, 8'd3);
    repeat (4) @(negedge clock);
    check("mid_vrd_low", 32'(vrd_n_o), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_rst_vrd",  32'(vrd_n_o), 32'd1);
    check("mid_rst_va",   32'(va_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_wval", 32'(write_valid_o), 32'd0);

    // Unknown opcode, then cleared by RESET opcode
    cmd(8'hEE, 8'h00);
    check("bad_op_err",  32'(error_bad_opcode_o), 32'd1);
    check("bad_op_busy", 32'(busy_o), 32'd0);
    cmd(8'h10, 8'h00);
    check("bad_op_clr",  32'(error_bad_opcode_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
